gps_uart_rx: RTL and testbench
==============================

# gps_uart_rx

Serial-to-byte front end for the GPS path: receives 8N1 asynchronous serial from the GPS module's TX line, recovers each byte, and emits it as a one-cycle `uart_data`/`uart_valid` strobe that feeds `GPS_parser_mod` directly. It sits between the board pin and the NMEA parser and has no backpressure, because the parser consumes one byte per strobe.

## Interface
- `CLKS_PER_BIT`, 10417, clock cycles per bit (100 MHz / 9600 baud); legal range ≥ 8.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  synchronous reset, active-low: `rst`=0 at a rising edge resets the block.
- `rx`  input  1  raw asynchronous serial line; idles high.
- `uart_data`  output  8  last received byte, LSB first on the line.
- `uart_valid`  output  1  one-cycle pulse: `uart_data` holds a new good byte.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low; the byte is discarded.
- `rx_busy`  output  1  high in every state except IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer with both flops reset to 1. `rxs` below means the synchronizer output.
- Bit counter width is `$clog2(CLKS_PER_BIT)`. Bit index is 3 bits. Shift register is 8 bits, shifted right with the new bit at [7].
- IDLE: counter=0. Falling `rxs` (1→0) moves the block to START.
- START: counts to `CLKS_PER_BIT/2 - 1` (integer division), then samples.
  - Sample = 1: glitch; return to IDLE with no output.
  - Sample = 0: clear counter and bit index; go to DATA.
- DATA: samples at counter = `CLKS_PER_BIT-1`, shifts the bit in and clears the counter. After bit index 7 it goes to STOP.
- STOP: samples at counter = `CLKS_PER_BIT-1`.
  - Sample = 1: load `uart_data` from the shift register, pulse `uart_valid`, go to IDLE.
  - Sample = 0: pulse `frame_err`, leave `uart_data` unchanged, go to RECOVER.
- RECOVER: waits for `rxs`=1, then goes to IDLE. A held-low line (break) is never interpreted as new start bits.
- `uart_data` holds its value until the next good byte.
- No FIFO and no overrun logic. The parser accepts one byte per `uart_valid` unconditionally.

## Timing
- Reset values: `uart_data`=0x00, `uart_valid`=0, `frame_err`=0, `rx_busy`=0, state IDLE, synchronizer flops = 1.
- Outputs are registered. `uart_valid` and `frame_err` are exactly one cycle wide and never asserted together.
- Latency: from the first `clk` edge that captures `rx`=0 at the start bit to `uart_valid` high is 2 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles. With `CLKS_PER_BIT`=16 this is 155 cycles.
- Back-to-back frames with zero idle time are received without loss: STOP→IDLE happens mid-stop-bit, before the next falling edge.
- Reset asserted mid-frame returns the block to IDLE next edge with no pulse. A frame already in progress when reset releases is ignored until `rxs` goes high and then falls again.

## Configuration
- Macro `GPS_UART_RX_MAJORITY_EN`.
- Defined: every sample point (START, DATA, STOP) takes the 2-of-3 majority of `rxs` at counter = target-1, target and target+1. The decision is made at target+1, and all counter targets shift by +1 so the frame length is unchanged. Latency increases by 1 cycle.
- Undefined: single sample at the target cycle, as described above.

## Test plan
- Reset, `CLKS_PER_BIT`=16, send 0x24 ('$') -> `uart_valid` pulses once, 155 cycles after the start-bit edge; `uart_data`=0x24; `frame_err` stays 0.
- Send "$GPGGA," (0x24 0x47 0x50 0x47 0x47 0x41 0x2C) back-to-back with no idle bits -> seven `uart_valid` pulses in order, with bytes matching exactly.
- Drive `rx` low for 4 cycles, then high -> no `uart_valid` or `frame_err`; `rx_busy` drops back to 0 within `CLKS_PER_BIT/2`+3 cycles.
- Send 0x4E with the stop bit forced to 0 and `rx` held low for 40 more cycles, then send 0x31 -> one `frame_err` pulse, `uart_data` unchanged, block in RECOVER until `rx` rises; then `uart_valid` with 0x31.
- Assert `rst`=0 for one cycle during data bit 4 of 0x33, then send 0x30 -> no pulse for the aborted byte; 0x30 is received correctly.
- Force a single-cycle high glitch at the data bit 0 sample point of 0x30 -> with `GPS_UART_RX_MAJORITY_EN`, `uart_data`=0x30; without it, `uart_data`=0x31.

Source files
------------

// File: rtl/gps_uart_rx.sv
// gps_uart_rx: 8N1 serial receiver for the GPS path, one uart_valid strobe per good byte.
// Build option GPS_UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module gps_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] uart_data,
    output logic       uart_valid,
    output logic       frame_err,
    output logic       rx_busy
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
`ifdef GPS_UART_RX_MAJORITY_EN
    localparam int unsigned START_TGT = CLKS_PER_BIT / 2;
`else
    localparam int unsigned START_TGT = CLKS_PER_BIT / 2 - 1;
`endif
    localparam int unsigned BIT_TGT = CLKS_PER_BIT - 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q;
    logic [1:0]    warm_q;
    logic [1:0]    hist_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_d;
    logic          valid_d, ferr_d;
    logic          rxs, fall, samp;

    assign rxs  = sync_q[1];
    assign fall = hist_q[1] & ~hist_q[0];

`ifdef GPS_UART_RX_MAJORITY_EN
    assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
    assign samp = rxs;
`endif

    // Synchronizer plus edge history; history stays cleared until the reset-value
    // ones have left the synchronizer, so a line held low through reset is no edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
            warm_q <= 2'b00;
            hist_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], rx};
            warm_q <= {warm_q[0], 1'b1};
            hist_q <= warm_q[1] ? {hist_q[0], rxs} : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            uart_data  <= '0;
            uart_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_busy    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shreg_q    <= shreg_d;
            uart_data  <= data_d;
            uart_valid <= valid_d;
            frame_err  <= ferr_d;
            rx_busy    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = uart_data;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: begin
                if (cnt_q == CW'(START_TGT)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = samp ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CW'(BIT_TGT)) begin
                    cnt_d   = '0;
                    shreg_d = {samp, shreg_q[7:1]};
                    if (idx_q == 3'd7) state_d = STOP;
                    else idx_d = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                // Decided mid-stop-bit so a back-to-back start edge is never missed.
                if (cnt_q == CW'(BIT_TGT)) begin
                    cnt_d = '0;
                    if (samp) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RECOVER;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RECOVER: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_gps_uart_rx.sv
// tb_gps_uart_rx: drives 8N1 frames into gps_uart_rx and scores every strobe
// against a frame-level expectation queue (byte, error flag, start time).
module tb_gps_uart_rx;
    localparam int unsigned C = 16;
    localparam int unsigned H = C / 2;
`ifdef GPS_UART_RX_MAJORITY_EN
    localparam int unsigned LAT = 2 + H + 9 * C + 2;
    localparam bit          MAJ = 1'b1;
`else
    localparam int unsigned LAT = 2 + H + 9 * C + 1;
    localparam bit          MAJ = 1'b0;
`endif

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         t0;
    } evt_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] uart_data;
    logic       uart_valid;
    logic       frame_err;
    logic       rx_busy;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;
    evt_t       exp_q[$];
    logic [7:0] nmea [7] = '{8'h24, 8'h47, 8'h50, 8'h47, 8'h47, 8'h41, 8'h2C};

    gps_uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .uart_data  (uart_data),
        .uart_valid (uart_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int unsigned n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Start bit is applied at a negedge, so the next posedge is the capture edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic glitch0);
        evt_t e;
        e.t0   = cyc + 1;
        e.err  = ~stop_ok;
        e.data = (glitch0 && !MAJ) ? (b | 8'h01) : b;
        exp_q.push_back(e);
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) begin
            if (i == 0 && glitch0) begin
                // one-cycle high pulse at the bit-0 sample point, H+1 cycles into the bit
                hold(1'b0, H + 1);
                hold(1'b1, 1);
                hold(1'b0, C - H - 2);
            end else begin
                hold(b[i], C);
            end
        end
        hold(stop_ok, C);
    endtask

    // Scoreboard: every strobe must match the oldest outstanding frame.
    initial begin
        evt_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) last_good = 8'h00;
            if (exp_q.size() > 0 && cyc > exp_q[0].t0 + int'(LAT) + 4) begin
                e = exp_q.pop_front();
                check_eq("evt_timeout", 32'(cyc - e.t0), LAT);
            end
            if (uart_valid || frame_err) begin
                check_eq("pulse_excl", 32'(uart_valid & frame_err), 0);
                check_eq("evt_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("evt_kind", 32'(frame_err), 32'(e.err));
                    check_eq("latency", 32'(cyc - e.t0), LAT);
                    if (!e.err) begin
                        check_eq("rx_byte", 32'(uart_data), 32'(e.data));
                        last_good = e.data;
                    end else begin
                        check_eq("ferr_data_hold", 32'(uart_data), 32'(last_good));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0]  b;
        logic        ok;
        int unsigned gap;
        bit          busy_seen;

        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_data", 32'(uart_data), 0);
        check_eq("rst_valid", 32'(uart_valid), 0);
        check_eq("rst_ferr", 32'(frame_err), 0);
        check_eq("rst_busy", 32'(rx_busy), 0);
        rst = 1'b1;
        hold(1'b1, 2 * C);

        send_frame(8'h24, 1'b1, 1'b0);
        hold(1'b1, C);

        for (int i = 0; i < 7; i++) send_frame(nmea[i], 1'b1, 1'b0);
        hold(1'b1, C);

        // runt start bit
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (4) begin
            @(negedge clk);
            busy_seen = busy_seen | rx_busy;
        end
        rx = 1'b1;
        for (int n = 0; n < int'(H) + 3 && rx_busy; n++) @(negedge clk);
        check_eq("runt_busy_seen", 32'(busy_seen), 1);
        check_eq("runt_busy_drop", 32'(rx_busy), 0);
        hold(1'b1, C);

        // framing error, then a held-low line
        send_frame(8'h4E, 1'b0, 1'b0);
        hold(1'b0, 40);
        check_eq("recover_busy", 32'(rx_busy), 1);
        check_eq("recover_data", 32'(uart_data), 32'h2C);
        hold(1'b1, 2 * C);
        check_eq("recover_exit", 32'(rx_busy), 0);
        send_frame(8'h31, 1'b1, 1'b0);
        hold(1'b1, C);

        // reset during data bit 4 of 0x33; sender abandons the frame
        b = 8'h33;
        hold(1'b0, C);
        for (int i = 0; i < 4; i++) hold(b[i], C);
        hold(b[4], 5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_eq("abort_busy", 32'(rx_busy), 0);
        check_eq("abort_data", 32'(uart_data), 0);
        hold(1'b1, 2 * C);
        send_frame(8'h30, 1'b1, 1'b0);
        hold(1'b1, C);

        send_frame(8'h30, 1'b1, 1'b1);
        hold(1'b1, C);

        // line already low when reset releases
        rx = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hold(1'b0, 3 * C);
        check_eq("break_busy", 32'(rx_busy), 0);
        hold(1'b1, 2 * C);

        for (int k = 0; k < 24; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(b, ok, 1'b0);
            gap = ok ? $urandom_range(0, 2 * C) : (C + $urandom_range(0, C));
            hold(1'b1, gap);
        end

        hold(1'b1, 3 * C);
        check_eq("drain", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
